// File: rtl/alu_pkg.sv
// Shared encodings for the ID/EX ALU issue path: ALU op codes, RV32I opcodes and
// funct7 selectors, plus the S-type immediate gather.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLL = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_SRA = 4'b1001
    } alu_op_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    function automatic logic [11:0] store_imm(input logic [31:0] instr);
        return {instr[31:25], instr[11:7]};
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I -> ALU decode: picks the op code and both operands, and flags
// anything that cannot be expressed as one of the eight ALU operations.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic [31:0]          instr,
    input  logic [REG_WIDTH-1:0] pc,
    input  logic [REG_WIDTH-1:0] rs1_data,
    input  logic [REG_WIDTH-1:0] rs2_data,
    output logic [REG_WIDTH-1:0] in1,
    output logic [REG_WIDTH-1:0] in2,
    output logic [3:0]           alu_op,
    output logic                 illegal
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [REG_WIDTH-1:0] i_imm;
    logic [REG_WIDTH-1:0] s_imm;
    logic [REG_WIDTH-1:0] u_imm;
    logic [REG_WIDTH-1:0] shamt;
    logic [11:0]          s_imm_raw;
    logic                 unused_rs_fields;
    alu_op_t              op;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign s_imm_raw = store_imm(instr);
    assign i_imm     = {{(REG_WIDTH-12){instr[31]}}, instr[31:20]};
    assign s_imm     = {{(REG_WIDTH-12){s_imm_raw[11]}}, s_imm_raw};
    // Bit 31 is replicated into the extension, so REG_WIDTH == 32 needs no special case.
    assign u_imm     = {{(REG_WIDTH-31){instr[31]}}, instr[30:12], 12'b0};
    assign shamt     = {{(REG_WIDTH-5){1'b0}}, instr[24:20]};
    // Register indices are resolved by the register file before this stage.
    assign unused_rs_fields = ^instr[19:15];

    always_comb begin
        op      = ALU_ADD;
        in1     = '0;
        in2     = '0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                in1 = rs1_data;
                in2 = rs2_data;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: op = ALU_ADD;
                    {F7_ALT,  3'b000}: op = ALU_SUB;
                    {F7_BASE, 3'b001}: op = ALU_SLL;
                    {F7_BASE, 3'b100}: op = ALU_XOR;
                    {F7_BASE, 3'b101}: op = ALU_SRL;
                    {F7_ALT,  3'b101}: op = ALU_SRA;
                    {F7_BASE, 3'b110}: op = ALU_OR;
                    {F7_BASE, 3'b111}: op = ALU_AND;
                    default:           illegal = 1'b1;
                endcase
            end
            OP_I: begin
                in1 = rs1_data;
                in2 = i_imm;
                case (funct3)
                    3'b000: op = ALU_ADD;
                    3'b100: op = ALU_XOR;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    3'b001: begin
                        in2 = shamt;
                        if (funct7 == F7_BASE) op = ALU_SLL;
                        else                   illegal = 1'b1;
                    end
                    3'b101: begin
                        in2 = shamt;
                        if (funct7 == F7_BASE)     op = ALU_SRL;
                        else if (funct7 == F7_ALT) op = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                in1 = rs1_data;
                in2 = i_imm;
            end
            OP_STORE: begin
                in1 = rs1_data;
                in2 = s_imm;
            end
            OP_LUI: begin
                in2 = u_imm;
            end
            OP_AUIPC: begin
                in1 = pc;
                in2 = u_imm;
            end
            OP_BRANCH: begin
                op  = ALU_SUB;
                in1 = rs1_data;
                in2 = rs2_data;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal words always leave with a clean, recognisable payload.
        if (illegal) begin
            op  = ALU_ADD;
            in1 = '0;
            in2 = '0;
        end
    end

    assign alu_op = op;

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes an instruction and presents registered ALU operands
// through a main/skid register pair with valid/ready on both sides and flush.
module alu_issue
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [REG_WIDTH-1:0] pc,
    input  logic [REG_WIDTH-1:0] rs1_data,
    input  logic [REG_WIDTH-1:0] rs2_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] in1,
    output logic [REG_WIDTH-1:0] in2,
    output logic [3:0]           alu_control,
    output logic                 illegal
);

    logic [REG_WIDTH-1:0] dec_in1;
    logic [REG_WIDTH-1:0] dec_in2;
    logic [3:0]           dec_op;
    logic                 dec_illegal;

    logic                 main_valid_reg, main_valid_next;
    logic [REG_WIDTH-1:0] main_in1_reg, main_in1_next;
    logic [REG_WIDTH-1:0] main_in2_reg, main_in2_next;
    logic [3:0]           main_op_reg, main_op_next;
    logic                 main_illegal_reg, main_illegal_next;

    logic                 skid_valid_reg, skid_valid_next;
    logic [REG_WIDTH-1:0] skid_in1_reg, skid_in1_next;
    logic [REG_WIDTH-1:0] skid_in2_reg, skid_in2_next;
    logic [3:0]           skid_op_reg, skid_op_next;
    logic                 skid_illegal_reg, skid_illegal_next;

    logic                 accept;
    logic                 drain;

    alu_ctrl_decode #(
        .REG_WIDTH (REG_WIDTH)
    ) u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .in1      (dec_in1),
        .in2      (dec_in2),
        .alu_op   (dec_op),
        .illegal  (dec_illegal)
    );

    // Ready depends only on state, so out_ready never reaches in_ready combinationally.
    assign in_ready = reset_n & ~skid_valid_reg;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = main_valid_reg & out_ready;

    always_comb begin
        main_valid_next   = main_valid_reg;
        main_in1_next     = main_in1_reg;
        main_in2_next     = main_in2_reg;
        main_op_next      = main_op_reg;
        main_illegal_next = main_illegal_reg;
        skid_valid_next   = skid_valid_reg;
        skid_in1_next     = skid_in1_reg;
        skid_in2_next     = skid_in2_reg;
        skid_op_next      = skid_op_reg;
        skid_illegal_next = skid_illegal_reg;

        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg || drain) begin
            // Main is free this cycle: the older skid entry goes first, else the new one.
            if (skid_valid_reg) begin
                main_valid_next   = 1'b1;
                main_in1_next     = skid_in1_reg;
                main_in2_next     = skid_in2_reg;
                main_op_next      = skid_op_reg;
                main_illegal_next = skid_illegal_reg;
                skid_valid_next   = 1'b0;
            end else if (accept) begin
                main_valid_next   = 1'b1;
                main_in1_next     = dec_in1;
                main_in2_next     = dec_in2;
                main_op_next      = dec_op;
                main_illegal_next = dec_illegal;
            end else begin
                main_valid_next   = 1'b0;
            end
        end else if (accept) begin
            skid_valid_next   = 1'b1;
            skid_in1_next     = dec_in1;
            skid_in2_next     = dec_in2;
            skid_op_next      = dec_op;
            skid_illegal_next = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_valid_reg   <= 1'b0;
            main_in1_reg     <= '0;
            main_in2_reg     <= '0;
            main_op_reg      <= ALU_ADD;
            main_illegal_reg <= 1'b0;
            skid_valid_reg   <= 1'b0;
            skid_in1_reg     <= '0;
            skid_in2_reg     <= '0;
            skid_op_reg      <= ALU_ADD;
            skid_illegal_reg <= 1'b0;
        end else begin
            main_valid_reg   <= main_valid_next;
            main_in1_reg     <= main_in1_next;
            main_in2_reg     <= main_in2_next;
            main_op_reg      <= main_op_next;
            main_illegal_reg <= main_illegal_next;
            skid_valid_reg   <= skid_valid_next;
            skid_in1_reg     <= skid_in1_next;
            skid_in2_reg     <= skid_in2_next;
            skid_op_reg      <= skid_op_next;
            skid_illegal_reg <= skid_illegal_next;
        end
    end

    assign out_valid   = main_valid_reg;
    assign in1         = main_in1_reg;
    assign in2         = main_in2_reg;
    assign alu_control = main_op_reg;
    assign illegal     = main_illegal_reg;

endmodule
